vec_mem_seq: RTL
================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter ELEN, default 32, element and memory word width; LANES = VLEN/ELEN (4 at defaults).
REQ-003 SHALL have parameter DATA_ADDR_WIDTH, default 10, byte-address width of data memory.
REQ-004 SHALL use one clock with asynchronous, active-high reset. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have req_valid in 1, request offered.
REQ-006 SHALL have req_ready out 1, request accepted this cycle when high with req_valid.
REQ-007 SHALL have req_we in 1, 1 = vector store, 0 = vector load.
REQ-008 SHALL have req_addr in DATA_ADDR_WIDTH, byte base address.
REQ-009 SHALL have req_lane_en in LANES, per-lane enable, bit i = element i.
REQ-010 SHALL have req_wdata in VLEN, store data, element i at bits [i*ELEN +: ELEN].
REQ-011 SHALL have mem_en out 1, memory access strobe.
REQ-012 SHALL have mem_we out 1, write strobe, qualified by mem_en.
REQ-013 SHALL have mem_addr out DATA_ADDR_WIDTH, byte address.
REQ-014 SHALL have mem_wdata out ELEN, write data.
REQ-015 SHALL have mem_rdata in ELEN, read data valid exactly one cycle after a read access.
REQ-016 SHALL have rsp_valid out 1, response available.
REQ-017 SHALL have rsp_ready in 1, response consumed when high with rsp_valid.
REQ-018 SHALL have rsp_rdata out VLEN, assembled load data.
REQ-019 SHALL have rsp_err out 1, misaligned-request flag.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL, on acceptance, register req_we, req_addr, req_lane_en and req_wdata; later input changes SHALL NOT affect the operation.
REQ-022 SHALL, on acceptance with req_addr[1:0] != 0, go to RESP next cycle with rsp_err = 1, rsp_rdata = 0, and issue no memory access.
REQ-023 SHALL, on aligned acceptance, enter ACCESS with lane counter 0 and clear rsp_err and the rsp_rdata register.
REQ-024 SHALL, in ACCESS, visit one lane per cycle, ascending 0..LANES-1; disabled lanes still consume their cycle.
REQ-025 SHALL, for lane i in ACCESS: mem_en = lane_en[i], mem_we = we, mem_addr = base + 4*i modulo 2^DATA_ADDR_WIDTH (wrap permitted), mem_wdata = element i.
REQ-026 SHALL keep mem_en = 0 in IDLE, DRAIN and RESP, and keep mem_we = 0 whenever mem_en = 0.
REQ-027 SHALL, for loads, capture mem_rdata into element i of rsp_rdata on the edge after lane i's access; disabled or store lanes read back 0.
REQ-028 SHALL go ACCESS -> DRAIN after lane LANES-1, and DRAIN -> RESP after one cycle, for loads and stores alike.
REQ-029 SHALL give fixed latency for aligned requests: rsp_valid first high in the cycle following the (LANES+1)th edge after the acceptance edge (5 edges at defaults).
REQ-030 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready; on handshake, go to IDLE; req_ready rises the next cycle, with no same-cycle re-accept.
REQ-031 SHALL complete a request with req_lane_en = 0 with normal latency, zero memory accesses and rsp_rdata = 0.

Reset
REQ-032 SHALL, when rst is asserted at any time (including mid-ACCESS), force IDLE asynchronously, abandon the operation with no response, and drive: req_ready 1, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.

Structure
REQ-033 SHALL place the state enum, LANES and the word byte-stride constant (4) in shared package vec_mem_pkg.
REQ-034 SHALL be a single module with no sub-module; lane counter and FSM SHALL be internal.

Verification
REQ-035 Load, addr 0x040, lane_en 4'b1111, memory words 0x11,0x22,0x33,0x44 -> mem_addr 0x040,0x044,0x048,0x04C on consecutive cycles; rsp_rdata = {0x44,0x33,0x22,0x11}, rsp_err 0, rsp_valid 5 edges after accept.
REQ-036 Store, addr 0x100, lane_en 4'b0101, wdata elements A,B,C,D -> writes only A@0x100 and C@0x108; no access in lane 1/3 cycles; rsp_valid at same latency.
REQ-037 Load, addr 0x3F8, lane_en 4'b1111 -> mem_addr 0x3F8,0x3FC,0x000,0x004 (wrap).
REQ-038 Load, addr 0x042 -> no mem_en; rsp_valid next cycle with rsp_err 1, rsp_rdata 0.
REQ-039 Hold rsp_ready low 3 cycles in RESP -> outputs stable; after handshake req_ready 1 next cycle; back-to-back request accepted then.
REQ-040 Assert rst during lane 2 of a load -> mem_en 0 immediately, IDLE, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared FSM state encoding and lane geometry constants
package vec_mem_pkg;

    localparam int VLEN_DEFAULT = 128;
    localparam int ELEN_DEFAULT = 32;
    localparam int LANES        = VLEN_DEFAULT / ELEN_DEFAULT;
    localparam int WORD_BYTES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } vm_state_e;

    function automatic int lane_count(input int vlen, input int elen);
        return vlen / elen;
    endfunction

endpackage

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - sequences one vector load/store as per-lane word accesses
module vec_mem_seq
    import vec_mem_pkg::*;
#(
    parameter int VLEN            = 128,
    parameter int ELEN            = 32,
    parameter int DATA_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
    input  logic [VLEN/ELEN-1:0]       req_lane_en,
    input  logic [VLEN-1:0]            req_wdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [ELEN-1:0]            mem_wdata,
    input  logic [ELEN-1:0]            mem_rdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [VLEN-1:0]            rsp_rdata,
    output logic                       rsp_err
);

    localparam int NLANES = lane_count(VLEN, ELEN);
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);

    vm_state_e                  r_state;
    vm_state_e                  w_next_state;
    logic [LANE_W-1:0]          r_lane;
    logic                       r_we;
    logic [DATA_ADDR_WIDTH-1:0] r_addr;
    logic [NLANES-1:0]          r_lane_en;
    logic [VLEN-1:0]            r_wdata;
    logic [VLEN-1:0]            r_rdata;
    logic                       r_err;
    logic                       r_rd_pending;
    logic [LANE_W-1:0]          r_rd_lane;

    logic                       w_accept;
    logic                       w_misaligned;
    logic                       w_last_lane;
    logic                       w_lane_active;
    logic                       w_lane_on;
    logic [DATA_ADDR_WIDTH-1:0] w_lane_off;

    assign w_accept      = req_valid && (r_state == ST_IDLE);
    assign w_misaligned  = (req_addr[1:0] != 2'b00);
    assign w_last_lane   = (r_lane == LAST_LANE);
    assign w_lane_active = (r_state == ST_ACCESS);
    assign w_lane_on     = w_lane_active && r_lane_en[r_lane];
    assign w_lane_off    = DATA_ADDR_WIDTH'(int'(r_lane) * WORD_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_misaligned ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_last_lane) begin
                    w_next_state = ST_DRAIN;
                end
            end
            // Extra cycle lets the last lane's read data return before responding.
            ST_DRAIN: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs are forced to zero outside ACCESS so reset shows clean zeros.
    assign mem_en    = w_lane_on;
    assign mem_we    = w_lane_on && r_we;
    assign mem_addr  = w_lane_active ? (r_addr + w_lane_off) : '0;
    assign mem_wdata = w_lane_active ? r_wdata[r_lane*ELEN +: ELEN] : '0;

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane       <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_lane_en    <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_lane    <= '0;
        end else begin
            r_rd_pending <= w_lane_on && !r_we;
            r_rd_lane    <= r_lane;
            // Memory returns data one cycle after the access, so capture is one lane behind.
            if (r_rd_pending) begin
                r_rdata[r_rd_lane*ELEN +: ELEN] <= mem_rdata;
            end
            if (w_accept) begin
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_lane_en <= req_lane_en;
                r_wdata   <= req_wdata;
                r_lane    <= '0;
                r_rdata   <= '0;
                r_err     <= w_misaligned;
            end else if (w_lane_active && !w_last_lane) begin
                r_lane <= r_lane + LANE_W'(1);
            end
        end
    end

endmodule
